hilo_mult: RTL
==============

HILO_MULT -- requirements
Module: hilo_mult

Interface
REQ-001 Parameter: WIDTH, 32, operand width; hi and lo are each WIDTH bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start_mult  input  1  request a multiply; from the main decoder for MULT/MULTU.
REQ-005 mult_sign  input  1  1 = signed (MULT), 0 = unsigned (MULTU); sampled with start_mult.
REQ-006 src_a  input  WIDTH  multiplicand (rs value); sampled with start_mult.
REQ-007 src_b  input  WIDTH  multiplier (rt value); sampled with start_mult.
REQ-008 hi_we  input  1  MTHI write strobe.
REQ-009 lo_we  input  1  MTLO write strobe.
REQ-010 wdata  input  WIDTH  data for hi_we/lo_we.
REQ-011 hi  output  WIDTH  HI register, read by MFHI path.
REQ-012 lo  output  WIDTH  LO register, read by MFLO path.
REQ-013 busy  output  1  high while a multiply is in flight; the hazard unit stalls MFHI/MFLO/MULT on it.
REQ-014 done  output  1  one-cycle pulse, the cycle after hi/lo take a multiply result.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and SIGN; busy SHALL equal (state != IDLE), decoded from registered state only.
REQ-016 In IDLE, start_mult=1 at edge T SHALL latch the operands and mult_sign and move to RUN with iteration count 0.
REQ-017 When signed, the operands SHALL be converted to magnitudes (0x80000000 gives magnitude 0x80000000 unsigned), and the result-negate flag SHALL be set to sign(a) XOR sign(b).
REQ-018 RUN SHALL perform one radix-2 shift-add step per cycle into a 2*WIDTH accumulator, for WIDTH steps (edges T+1..T+WIDTH); after the final step it SHALL go to SIGN.
REQ-019 At edge T+WIDTH+1, SIGN SHALL write {hi,lo} with the product, two's-complement negated if the negate flag is set, and return to IDLE.
REQ-020 done SHALL be high exactly one cycle, from edge T+WIDTH+1 to the next edge; busy SHALL be high for exactly WIDTH+1 cycles.
REQ-021 start_mult while busy SHALL be ignored, with no restart and no queueing.
REQ-022 hi_we/lo_we in IDLE SHALL write wdata to hi/lo at that edge; hi_we/lo_we while busy SHALL be ignored.
REQ-023 start_mult together with hi_we/lo_we in IDLE: the write SHALL take effect at that edge, and the multiply result SHALL overwrite it at completion.
REQ-024 hi and lo SHALL hold their values between writes; they SHALL NOT change during RUN.
REQ-025 Zero operands SHALL still take the full WIDTH+1 cycles; there is no early termination.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, busy=0, done=0, hi=0, lo=0, count=0, and clear the operand and negate registers.
REQ-027 Reset asserted mid-RUN or in SIGN SHALL abort the operation; no result is written after release.
REQ-028 After rst_n deasserts, the first start_mult SHALL be accepted on the first rising edge.

Verification
REQ-029 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy 33 cycles; hi=0xFFFFFFFE, lo=0x00000001; done pulses once.
REQ-030 MULT a=0xFFFFFFFF(-1), b=0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFFB; MULT a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-031 MULT 7x6 started; a second start_mult (3x3) at cycle 10 of busy -> hi=0, lo=42; busy falls after 33 cycles with no second operation.
REQ-032 IDLE: hi_we, wdata=0x1234 -> hi=0x1234 next edge; lo_we during busy -> lo unchanged until the multiply result lands.
REQ-033 rst_n pulsed low at cycle 15 of RUN -> hi=lo=0, busy=0 at once; no done pulse; a fresh MULTU 2x3 then gives lo=6 after 33 cycles.
REQ-034 Random signed and unsigned operand pairs (≥1000) -> {hi,lo} matches a 64-bit reference product in every case.

Source files
------------

// File: rtl/hilo_mult.sv
// HI/LO register pair with a sequential radix-2 shift-add multiplier.
// MULT/MULTU take WIDTH+1 cycles; MTHI/MTLO write directly while idle.
module hilo_mult #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_mult,
  input  logic             mult_sign,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SIGN
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [PW-1:0]   acc_q;
  logic            neg_q;
  logic            done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             neg_d;
  logic [WIDTH:0]   sum;
  logic [PW-1:0]    acc_d;
  logic [PW-1:0]    prod;
  logic             last;

  // Most-negative input maps onto itself, which is the correct unsigned magnitude.
  always_comb begin
    mag_a = src_a;
    mag_b = src_b;
    if (mult_sign && src_a[WIDTH-1]) mag_a = -src_a;
    if (mult_sign && src_b[WIDTH-1]) mag_b = -src_b;
    neg_d = mult_sign & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
  end

  // Add into the upper half, then shift the whole accumulator right by one.
  always_comb begin
    sum = {1'b0, acc_q[PW-1:WIDTH]};
    if (mplier_q[0]) sum = sum + {1'b0, mcand_q};
    acc_d = {sum, acc_q[WIDTH-1:1]};
    prod  = neg_q ? -acc_q : acc_q;
    last  = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          if (start_mult) begin
            mcand_q  <= mag_a;
            mplier_q <= mag_b;
            neg_q    <= neg_d;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (last) state_q <= SIGN;
        end
        SIGN: begin
          hi_q    <= prod[PW-1:WIDTH];
          lo_q    <= prod[WIDTH-1:0];
          done_q  <= 1'b1;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
